// File: rtl/field_access_pkg.sv
// Shared types and constants for the field access responder.
// The read-only field mask is enabled by defining FIELD_ACCESS_RO_MASK_EN.
package field_access_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } fa_state_e;

  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // Identifiers are compared at 32 bits so any ID_W works against NUM_FIELDS.
  function automatic logic id_in_range(input logic [31:0] id, input logic [31:0] num_fields);
    return id < num_fields;
  endfunction

endpackage

// File: rtl/field_access_bank.sv
// Field storage for the responder: one write port, one asynchronous read port,
// every field cleared by the asynchronous reset.
module field_access_bank #(
  parameter int NUM_FIELDS = 8,
  parameter int DATA_W     = 32,
  parameter int AW         = $clog2(NUM_FIELDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [NUM_FIELDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Callers only use the read value for in-range addresses.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/field_access_responder.sv
// Get/set responder over a bank of NUM_FIELDS registers with a counted response channel.
// Optional read-only field mask: define FIELD_ACCESS_RO_MASK_EN to add parameter RO_MASK.
module field_access_responder
  import field_access_pkg::*;
#(
  parameter int NUM_FIELDS = 8,
  parameter int DATA_W     = 32,
  parameter int ID_W       = $clog2(NUM_FIELDS)
`ifdef FIELD_ACCESS_RO_MASK_EN
  ,
  parameter logic [NUM_FIELDS-1:0] RO_MASK = '0
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ID_W-1:0]    req_id,
  input  logic [DATA_W-1:0]  req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_error,
  output logic [COUNT_W-1:0] access_count,
  output logic               fsm_state
);

  localparam int AW = $clog2(NUM_FIELDS);

  // Handshake: a beat transfers on the rising edge where valid & ready are both 1;
  // valid and payload stay stable until that edge, ready may change freely.
  fa_state_e           state_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_error_q;
  logic [COUNT_W-1:0]  count_q;
  logic [COUNT_W-1:0]  count_d;

  logic                xfer;
  logic                in_range;
  logic                ro_hit;
  logic                req_err;
  logic                bank_we;
  logic [AW-1:0]       idx;
  logic [DATA_W-1:0]   rd_data;

  assign idx      = req_id[AW-1:0];
  assign in_range = id_in_range(32'(req_id), 32'(NUM_FIELDS));

`ifdef FIELD_ACCESS_RO_MASK_EN
  assign ro_hit = in_range && RO_MASK[idx];
`else
  assign ro_hit = 1'b0;
`endif

  assign req_ready = rst_n && (state_q == IDLE);
  assign xfer      = req_valid && req_ready;
  assign req_err   = !in_range || (req_write && ro_hit);
  assign bank_we   = xfer && req_write && !req_err;
  assign count_d   = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_W'(1);

  field_access_bank #(
    .NUM_FIELDS (NUM_FIELDS),
    .DATA_W     (DATA_W),
    .AW         (AW)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bank_we),
    .waddr_i (idx),
    .wdata_i (req_data),
    .raddr_i (idx),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      count_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= (!req_write && in_range) ? rd_data : '0;
            rsp_error_q <= req_err;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            count_q     <= count_d;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_error    = rsp_error_q;
  assign access_count = count_q;
  assign fsm_state    = state_q;

endmodule
